// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational; updates, flush and statistics take effect at the next edge.
module branch_predictor #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  lu_pc,
   output logic             lu_hit,
   output logic             lu_taken,
   output logic [XLEN-1:0]  lu_target,
   input  logic             upd_valid,
   input  logic [XLEN-1:0]  upd_pc,
   input  logic             upd_taken,
   input  logic [XLEN-1:0]  upd_target,
   input  logic             upd_pred_taken,
   input  logic [XLEN-1:0]  upd_pred_target,
   input  logic             flush,
   output logic [CNT_W-1:0] stat_updates,
   output logic [CNT_W-1:0] stat_mispredicts,
   output logic             mispredict
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic             valid_q [ENTRIES];
   logic [1:0]       cnt_q   [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [XLEN-1:0]  tgt_q   [ENTRIES];

   logic [CNT_W-1:0] stat_upd_q, stat_upd_d;
   logic [CNT_W-1:0] stat_mis_q, stat_mis_d;
   logic             mispredict_q, mispredict_d;

   logic [IDX_W-1:0] lu_idx, upd_idx;
   logic [TAG_W-1:0] lu_tag, upd_tag;
   logic             upd_hit;
   logic             entry_we;
   logic [1:0]       cnt_d;

   assign lu_idx  = lu_pc[IDX_W+1:2];
   assign lu_tag  = lu_pc[XLEN-1:IDX_W+2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

   assign lu_hit    = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
   assign lu_taken  = lu_hit && cnt_q[lu_idx][1];
   assign lu_target = lu_hit ? tgt_q[lu_idx] : lu_pc + XLEN'(4);

   assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign entry_we = upd_valid && !flush && (upd_hit || upd_taken);

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d        = 2'b10;
      mispredict_d = 1'b0;
      stat_upd_d   = stat_upd_q;
      stat_mis_d   = stat_mis_q;
      if (upd_hit) begin
         if (upd_taken) cnt_d = (cnt_q[upd_idx] == 2'b11) ? 2'b11 : cnt_q[upd_idx] + 2'd1;
         else           cnt_d = (cnt_q[upd_idx] == 2'b00) ? 2'b00 : cnt_q[upd_idx] - 2'd1;
      end
      if (upd_valid) begin
         mispredict_d = (upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));
         if (stat_upd_q != '1) stat_upd_d = stat_upd_q + CNT_W'(1);
         if (mispredict_d && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= 2'b01;
         end
         stat_upd_q   <= '0;
         stat_mis_q   <= '0;
         mispredict_q <= 1'b0;
      end else begin
         if (flush) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
         end else if (entry_we) begin
            valid_q[upd_idx] <= 1'b1;
            cnt_q[upd_idx]   <= cnt_d;
         end
         stat_upd_q   <= stat_upd_d;
         stat_mis_q   <= stat_mis_d;
         mispredict_q <= mispredict_d;
      end
   end

   // NOTE: tags and targets are not reset; they are only observed behind a set valid bit.
   always_ff @(posedge clk) begin
      if (!rst && entry_we) begin
         tag_q[upd_idx] <= upd_tag;
         if (upd_taken) tgt_q[upd_idx] <= upd_target;
      end
   end

   assign stat_updates     = stat_upd_q;
   assign stat_mispredicts = stat_mis_q;
   assign mispredict       = mispredict_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them in the cycle they are due.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lu_pc;
   logic        lu_hit, lu_taken;
   logic [31:0] lu_target;
   logic        upd_valid, upd_taken, upd_pred_taken, flush;
   logic [31:0] upd_pc, upd_target, upd_pred_target;
   logic [3:0]  stat_updates, stat_mispredicts;
   logic        mispredict;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      string       name;
      int          cyc;
      bit          is_lu;
      logic        hit;
      logic        taken;
      logic [31:0] tgt;
      logic [3:0]  su;
      logic [3:0]  sm;
      logic        mp;
   } exp_t;

   exp_t sb_q[$];

   branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .lu_pc(lu_pc), .lu_hit(lu_hit), .lu_taken(lu_taken), .lu_target(lu_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target), .flush(flush),
      .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts),
      .mispredict(mispredict)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Lookup outputs are due in the drive cycle; registered outputs one cycle later.
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (e.is_lu) begin
            if (lu_hit !== e.hit || lu_taken !== e.taken || lu_target !== e.tgt) begin
               errors++;
               $display("FAIL %s lookup: got hit=%b taken=%b target=%h, expected hit=%b taken=%b target=%h",
                        e.name, lu_hit, lu_taken, lu_target, e.hit, e.taken, e.tgt);
            end
         end else begin
            if (stat_updates !== e.su || stat_mispredicts !== e.sm || mispredict !== e.mp) begin
               errors++;
               $display("FAIL %s stats: got upd=%0d mis=%0d mp=%b, expected upd=%0d mis=%0d mp=%b",
                        e.name, stat_updates, stat_mispredicts, mispredict, e.su, e.sm, e.mp);
            end
         end
      end
   end

   task automatic step(input string name, input logic r, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic upt, input logic [31:0] uptg,
                       input logic fl, input logic eh, input logic et, input logic [31:0] etg,
                       input logic [3:0] esu, input logic [3:0] esm, input logic emp);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; lu_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
      upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg; flush = fl;
      e.name = name; e.cyc = cyc; e.is_lu = 1'b1;
      e.hit = eh; e.taken = et; e.tgt = etg; e.su = '0; e.sm = '0; e.mp = 1'b0;
      sb_q.push_back(e);
      e.cyc = cyc + 1; e.is_lu = 1'b0;
      e.su = esu; e.sm = esm; e.mp = emp;
      sb_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; lu_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
      upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; flush = 1'b0;
      repeat (2) @(posedge clk);

      //    name          rst lu_pc         uv  upd_pc      ut  utgt        upt  uptgt     fl   hit tkn tgt           su mis mp
      step("reset_lu",    0, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 0, 32'h104,       0, 0, 0);
      step("wrap_pc4",    0, 32'hFFFFFFFC, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 0, 32'h0,         0, 0, 0);
      step("alloc",       0, 32'h100,      1, 32'h100, 1, 32'h80,  0, 32'h0,   0,  0, 0, 32'h104,       1, 1, 1);
      step("alloc_vis",   0, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  1, 1, 32'h80,        1, 1, 0);
      step("strengthen",  0, 32'h100,      1, 32'h100, 1, 32'h80,  1, 32'h80,  0,  1, 1, 32'h80,        2, 1, 0);
      step("nt_1",        0, 32'h100,      1, 32'h100, 0, 32'h0,   1, 32'h80,  0,  1, 1, 32'h80,        3, 2, 1);
      step("nt_2",        0, 32'h100,      1, 32'h100, 0, 32'h0,   1, 32'h80,  0,  1, 1, 32'h80,        4, 3, 1);
      step("nt_3",        0, 32'h100,      1, 32'h100, 0, 32'h0,   0, 32'h0,   0,  1, 0, 32'h80,        5, 3, 0);
      step("nt_4",        0, 32'h100,      1, 32'h100, 0, 32'h0,   0, 32'h0,   0,  1, 0, 32'h80,        6, 3, 0);
      step("sat_low",     0, 32'h100,      1, 32'h100, 1, 32'h90,  0, 32'h0,   0,  1, 0, 32'h80,        7, 4, 1);
      step("tgt_upd",     0, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  1, 0, 32'h90,        7, 4, 0);
      step("tgt_mis",     0, 32'h100,      1, 32'h100, 1, 32'hA0,  1, 32'h90,  0,  1, 0, 32'h90,        8, 5, 1);
      step("tgt_mis_vis", 0, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  1, 1, 32'hA0,        8, 5, 0);
      step("alias_alloc", 0, 32'h140,      1, 32'h140, 1, 32'h200, 0, 32'h0,   0,  0, 0, 32'h144,       9, 6, 1);
      step("alias_old",   0, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 0, 32'h104,       9, 6, 0);
      step("alias_new",   0, 32'h140,      1, 32'h108, 0, 32'h0,   0, 32'h0,   0,  1, 1, 32'h200,      10, 6, 0);
      step("miss_nt",     0, 32'h108,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 0, 32'h10C,      10, 6, 0);
      step("pc_low_bits", 0, 32'h142,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  1, 1, 32'h200,      10, 6, 0);
      step("same_cycle",  0, 32'h140,      1, 32'h140, 1, 32'h300, 1, 32'h200, 0,  1, 1, 32'h200,      11, 7, 1);
      step("next_cycle",  0, 32'h140,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  1, 1, 32'h300,      11, 7, 0);
      step("flush_upd",   0, 32'h140,      1, 32'h180, 1, 32'h400, 0, 32'h0,   1,  1, 1, 32'h300,      12, 8, 1);
      step("flush_vis",   0, 32'h140,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 0, 32'h144,      12, 8, 0);
      step("flush_noupd", 0, 32'h180,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 0, 32'h184,      12, 8, 0);
      step("rst_override",1, 32'h100,      1, 32'h100, 1, 32'h500, 0, 32'h0,   1,  0, 0, 32'h104,       0, 0, 0);
      step("rst_discard", 0, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  0, 0, 32'h104,       0, 0, 0);

      for (int k = 1; k <= 20; k++) begin
         step("stat_sat", 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0,
              (k == 1) ? 1'b0 : 1'b1, (k == 1) ? 1'b0 : 1'b1,
              (k == 1) ? 32'h204 : 32'h600,
              4'((k > 15) ? 15 : k), 4'((k > 15) ? 15 : k), 1'b1);
      end
      step("stat_hold",   0, 32'h200,      0, 32'h0,   0, 32'h0,   0, 32'h0,   0,  1, 1, 32'h600,      15, 15, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
